// File: rtl/linebuf_scanout.sv
// Line-buffer scan-out: reads a double-banked line buffer in step with the
// display enable, replicates pixels horizontally, repeats lines vertically and
// hands each finished bank back to the writer with the next line to fetch.
module linebuf_scanout #(
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned SCALE_X     = 1,
   parameter int unsigned LINE_REPEAT = 1,
   parameter int unsigned V_LINES     = 480
) (
   input  logic       clk_rd,
   input  logic       rst_rd,
   input  logic       frame_start,
   input  logic       vid_de,
   output logic       bank_rd,
   output logic [9:0] addr_rd,
   input  logic [7:0] data_rd,
   output logic       pix_valid,
   output logic [7:0] pix_iter8,
   output logic       fill_req,
   output logic       fill_bank,
   output logic [9:0] fill_line,
   output logic       overrun,
   output logic       frame_err
);

   localparam int unsigned XW  = 11;
   localparam int unsigned XCW = 12;
   localparam int unsigned AW  = 10;
   localparam int unsigned LW  = 10;
   localparam int unsigned RW  = 2;

   localparam int unsigned    X_LIMIT     = H_ACTIVE * SCALE_X;
   localparam logic [XCW-1:0] X_LIMIT_W   = XCW'(X_LIMIT);
   localparam logic [XW-1:0]  ADDR_MAX    = XW'(H_ACTIVE - 1);
   localparam logic [RW-1:0]  REP_LAST    = RW'(LINE_REPEAT - 1);
   localparam logic [LW-1:0]  LINE_LAST   = LW'(V_LINES - 1);
   localparam logic [LW-1:0]  LINE_PENULT = LW'(V_LINES - 2);

   typedef enum logic {
      SHOW    = 1'b0,
      RELEASE = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [XW-1:0]  x_q, x_d;
   logic           pix_valid_q, pix_valid_d;
   logic           in_range_q, in_range_d;
   logic           bank_q, bank_d;
   logic           fill_req_q, fill_req_d;
   logic           fill_bank_q, fill_bank_d;
   logic [LW-1:0]  fill_line_q, fill_line_d;
   logic           overrun_q, overrun_d;
   logic           frame_err_q, frame_err_d;
   logic [LW-1:0]  src_line_q, src_line_d;
   logic [RW-1:0]  rep_cnt_q, rep_cnt_d;

   logic [XW-1:0]  x_c;
   logic [XW-1:0]  addr_raw_c;
   logic           in_range_c;
   logic           line_end_c;
   logic           fs_c;
   logic [LW-1:0]  src_next_c;
   logic [LW-1:0]  fill_next_c;

   // Horizontal position, read address and range check for the current cycle
   always_comb begin
      x_c        = vid_de ? x_q : '0;
      x_d        = '0;
      addr_raw_c = x_c;
      if (vid_de) begin
         x_d = (x_q == '1) ? x_q : x_q + XW'(1);
      end
      if (SCALE_X == 2) begin
         addr_raw_c = x_c >> 1;
      end
      addr_rd     = (addr_raw_c > ADDR_MAX) ? AW'(ADDR_MAX) : AW'(addr_raw_c);
      in_range_c  = {1'b0, x_c} < X_LIMIT_W;
      in_range_d  = vid_de & in_range_c;
      pix_valid_d = vid_de;
      overrun_d   = overrun_q | (vid_de & ~in_range_c);
   end

   // Pixel output follows the one-cycle read latency of the line buffer
   always_comb begin
      pix_iter8 = (pix_valid_q && in_range_q) ? data_rd : '0;
   end

   // Source line successors, wrapping at the frame height
   always_comb begin
      src_next_c  = (src_line_q == LINE_LAST) ? '0 : src_line_q + LW'(1);
      fill_next_c = src_line_q + LW'(2);
      if (src_line_q == LINE_LAST) begin
         fill_next_c = LW'(1);
      end else if (src_line_q == LINE_PENULT) begin
         fill_next_c = '0;
      end
   end

   // Line-repeat / bank-release state machine and frame resynchronisation
   always_comb begin
      state_d     = state_q;
      bank_d      = bank_q;
      fill_req_d  = fill_req_q;
      fill_bank_d = fill_bank_q;
      fill_line_d = fill_line_q;
      frame_err_d = frame_err_q;
      src_line_d  = src_line_q;
      rep_cnt_d   = rep_cnt_q;

      line_end_c = pix_valid_q & ~vid_de;
      fs_c       = frame_start & ~vid_de;

      if (frame_start && (src_line_q != '0)) begin
         frame_err_d = 1'b1;
      end

      case (state_q)
         SHOW: begin
            if (line_end_c && !fs_c) begin
               if (rep_cnt_q == REP_LAST) begin
                  state_d = RELEASE;
               end else begin
                  rep_cnt_d = rep_cnt_q + RW'(1);
               end
            end
         end
         RELEASE: begin
            bank_d      = ~bank_q;
            fill_req_d  = ~fill_req_q;
            fill_bank_d = bank_q;
            if (!fs_c) begin
               fill_line_d = fill_next_c;
            end
            src_line_d  = src_next_c;
            rep_cnt_d   = '0;
            state_d     = SHOW;
         end
         default: begin
            state_d = SHOW;
         end
      endcase

      // A new frame wins over any line advance in the same cycle
      if (fs_c) begin
         src_line_d = '0;
         rep_cnt_d  = '0;
      end
   end

   // State registers
   always_ff @(posedge clk_rd or posedge rst_rd) begin
      if (rst_rd) begin
         state_q     <= SHOW;
         x_q         <= '0;
         pix_valid_q <= 1'b0;
         in_range_q  <= 1'b0;
         bank_q      <= 1'b0;
         fill_req_q  <= 1'b0;
         fill_bank_q <= 1'b0;
         fill_line_q <= '0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
         src_line_q  <= '0;
         rep_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         pix_valid_q <= pix_valid_d;
         in_range_q  <= in_range_d;
         bank_q      <= bank_d;
         fill_req_q  <= fill_req_d;
         fill_bank_q <= fill_bank_d;
         fill_line_q <= fill_line_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
         src_line_q  <= src_line_d;
         rep_cnt_q   <= rep_cnt_d;
      end
   end

   assign bank_rd   = bank_q;
   assign pix_valid = pix_valid_q;
   assign fill_req  = fill_req_q;
   assign fill_bank = fill_bank_q;
   assign fill_line = fill_line_q;
   assign overrun   = overrun_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_linebuf_scanout.sv
// Scoreboard bench: three instances (base, 2x horizontal scale, 2x line
// repeat) each with a small two-bank line-buffer model.
module tb_linebuf_scanout;

   localparam int N = 3;

   logic       clk = 1'b0;
   logic       rst         [N];
   logic       frame_start [N];
   logic       vid_de      [N];
   logic       bank_rd     [N];
   logic [9:0] addr_rd     [N];
   logic [7:0] data_rd     [N];
   logic       pix_valid   [N];
   logic [7:0] pix_iter8   [N];
   logic       fill_req    [N];
   logic       fill_bank   [N];
   logic [9:0] fill_line   [N];
   logic       overrun     [N];
   logic       frame_err   [N];

   logic [7:0] mem [2][4];

   int pix_q  [N][$];
   int fill_q [N][$];
   int checks = 0;
   int errors = 0;
   int exp_addr [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 3, 3};
   int exp_pix2 [10] = '{10, 10, 11, 11, 12, 12, 13, 13, 0, 0};

   always #5 clk = ~clk;

   linebuf_scanout #(.H_ACTIVE(4), .SCALE_X(1), .LINE_REPEAT(1), .V_LINES(4)) u_base (
      .clk_rd(clk), .rst_rd(rst[0]), .frame_start(frame_start[0]), .vid_de(vid_de[0]),
      .bank_rd(bank_rd[0]), .addr_rd(addr_rd[0]), .data_rd(data_rd[0]),
      .pix_valid(pix_valid[0]), .pix_iter8(pix_iter8[0]), .fill_req(fill_req[0]),
      .fill_bank(fill_bank[0]), .fill_line(fill_line[0]), .overrun(overrun[0]),
      .frame_err(frame_err[0]));

   linebuf_scanout #(.H_ACTIVE(4), .SCALE_X(2), .LINE_REPEAT(1), .V_LINES(4)) u_scale (
      .clk_rd(clk), .rst_rd(rst[1]), .frame_start(frame_start[1]), .vid_de(vid_de[1]),
      .bank_rd(bank_rd[1]), .addr_rd(addr_rd[1]), .data_rd(data_rd[1]),
      .pix_valid(pix_valid[1]), .pix_iter8(pix_iter8[1]), .fill_req(fill_req[1]),
      .fill_bank(fill_bank[1]), .fill_line(fill_line[1]), .overrun(overrun[1]),
      .frame_err(frame_err[1]));

   linebuf_scanout #(.H_ACTIVE(4), .SCALE_X(1), .LINE_REPEAT(2), .V_LINES(4)) u_rep (
      .clk_rd(clk), .rst_rd(rst[2]), .frame_start(frame_start[2]), .vid_de(vid_de[2]),
      .bank_rd(bank_rd[2]), .addr_rd(addr_rd[2]), .data_rd(data_rd[2]),
      .pix_valid(pix_valid[2]), .pix_iter8(pix_iter8[2]), .fill_req(fill_req[2]),
      .fill_bank(fill_bank[2]), .fill_line(fill_line[2]), .overrun(overrun[2]),
      .frame_err(frame_err[2]));

   // Synchronous line-buffer model: data one cycle after the address
   always @(posedge clk) begin
      for (int d = 0; d < N; d++) begin
         data_rd[d] <= mem[bank_rd[d]][addr_rd[d][1:0]];
      end
   end

   task automatic chk(input string name, input int d, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s dut%0d got %0d expected %0d at %0t", name, d, got, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every pixel strobe and fill_req toggle
   task automatic monitor();
      logic fr_prev  [N];
      logic rst_prev [N];
      for (int d = 0; d < N; d++) begin
         fr_prev[d]  = 1'b0;
         rst_prev[d] = 1'b1;
      end
      forever begin
         @(negedge clk);
         for (int d = 0; d < N; d++) begin
            if (!rst[d] && !rst_prev[d]) begin
               if (pix_valid[d]) begin
                  if (pix_q[d].size() == 0) chk("unexpected_pixel", d, int'(pix_iter8[d]), -1);
                  else chk("pixel", d, int'(pix_iter8[d]), pix_q[d].pop_front());
               end
               if (fill_req[d] != fr_prev[d]) begin
                  if (fill_q[d].size() == 0)
                     chk("unexpected_fill", d, int'({bank_rd[d], fill_bank[d], fill_line[d]}), -1);
                  else
                     chk("fill{bank,fbank,fline}", d,
                         int'({bank_rd[d], fill_bank[d], fill_line[d]}), fill_q[d].pop_front());
               end
            end
            fr_prev[d]  = fill_req[d];
            rst_prev[d] = rst[d];
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_line(input int d, input int bank);
      for (int i = 0; i < 4; i++) pix_q[d].push_back((bank != 0 ? 20 : 10) + i);
   endtask

   task automatic push_fill(input int d, input int bank_after, input int fbank, input int fline);
      fill_q[d].push_back((bank_after << 11) | (fbank << 10) | fline);
   endtask

   task automatic run_line(input int d, input int n);
      vid_de[d] = 1'b1;
      repeat (n) tick();
      vid_de[d] = 1'b0;
      repeat (4) tick();
   endtask

   task automatic pulse_fs(input int d);
      frame_start[d] = 1'b1;
      tick();
      frame_start[d] = 1'b0;
      tick();
   endtask

   task automatic check_reset(input int d);
      chk("rst_bank_rd",   d, int'(bank_rd[d]),   0);
      chk("rst_addr_rd",   d, int'(addr_rd[d]),   0);
      chk("rst_pix_valid", d, int'(pix_valid[d]), 0);
      chk("rst_pix_iter8", d, int'(pix_iter8[d]), 0);
      chk("rst_fill_req",  d, int'(fill_req[d]),  0);
      chk("rst_fill_bank", d, int'(fill_bank[d]), 0);
      chk("rst_fill_line", d, int'(fill_line[d]), 0);
      chk("rst_overrun",   d, int'(overrun[d]),   0);
      chk("rst_frame_err", d, int'(frame_err[d]), 0);
   endtask

   initial begin
      for (int a = 0; a < 4; a++) begin
         mem[0][a] = 8'(10 + a);
         mem[1][a] = 8'(20 + a);
      end
      for (int d = 0; d < N; d++) begin
         rst[d] = 1'b1;
         frame_start[d] = 1'b0;
         vid_de[d] = 1'b0;
      end
      fork
         monitor();
      join_none

      repeat (3) tick();
      for (int d = 0; d < N; d++) check_reset(d);
      for (int d = 0; d < N; d++) rst[d] = 1'b0;
      tick();

      // Base: basic scan, bank swap and fill wrap over one frame
      pulse_fs(0);
      chk("frame_err_clean", 0, int'(frame_err[0]), 0);
      push_line(0, 0); push_fill(0, 1, 0, 2); run_line(0, 4);
      push_line(0, 1); push_fill(0, 0, 1, 3); run_line(0, 4);
      push_line(0, 0); push_fill(0, 1, 0, 0); run_line(0, 4);
      push_line(0, 1); push_fill(0, 0, 1, 1); run_line(0, 4);
      chk("overrun_clean", 0, int'(overrun[0]), 0);

      // Base: early frame_start after 3 lines
      push_line(0, 0); push_fill(0, 1, 0, 2); run_line(0, 4);
      push_line(0, 1); push_fill(0, 0, 1, 3); run_line(0, 4);
      push_line(0, 0); push_fill(0, 1, 0, 0); run_line(0, 4);
      pulse_fs(0);
      chk("frame_err_set", 0, int'(frame_err[0]), 1);
      chk("bank_kept", 0, int'(bank_rd[0]), 1);
      push_line(0, 1); push_fill(0, 0, 1, 2); run_line(0, 4);

      // Base: reset mid-line, then a line on the first edge after release
      pix_q[0].push_back(10);
      vid_de[0] = 1'b1;
      tick();
      tick();
      chk("midline_valid_before", 0, int'(pix_valid[0]), 1);
      rst[0] = 1'b1;
      #1;
      check_reset(0);
      vid_de[0] = 1'b0;
      tick();
      tick();
      rst[0] = 1'b0;
      push_line(0, 0); push_fill(0, 1, 0, 2); run_line(0, 4);

      // Scale x2 with overrun past the active width
      chk("overrun_before", 1, int'(overrun[1]), 0);
      for (int i = 0; i < 10; i++) pix_q[1].push_back(exp_pix2[i]);
      push_fill(1, 1, 0, 2);
      for (int i = 0; i < 10; i++) begin
         vid_de[1] = 1'b1;
         #1;
         chk("addr_rd_scale", 1, int'(addr_rd[1]), exp_addr[i]);
         tick();
      end
      vid_de[1] = 1'b0;
      repeat (4) tick();
      chk("overrun_after", 1, int'(overrun[1]), 1);

      // Line repeat x2: release only after the second showing
      push_line(2, 0); run_line(2, 4);
      chk("no_release_first_show", 2, int'(fill_req[2]), 0);
      push_line(2, 0); push_fill(2, 1, 0, 2); run_line(2, 4);
      push_line(2, 1); run_line(2, 4);
      chk("no_release_third_show", 2, int'(fill_req[2]), 1);
      push_line(2, 1); push_fill(2, 0, 1, 3); run_line(2, 4);

      repeat (5) tick();
      for (int d = 0; d < N; d++) begin
         chk("pixels_left", d, pix_q[d].size(), 0);
         chk("fills_left", d, fill_q[d].size(), 0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
